// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART frame arbiter.
package uart_tx_arbiter_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned GRANT_W   = 2;

  // Byte slices of a frame, sent most-significant byte first
  localparam int unsigned BYTE0_LSB = 16;
  localparam int unsigned BYTE1_LSB = 8;
  localparam int unsigned BYTE2_LSB = 0;

  // One-hot owner encodings {scr, man}
  localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
  localparam logic [GRANT_W-1:0] GRANT_MAN  = 2'b01;
  localparam logic [GRANT_W-1:0] GRANT_SCR  = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND0 = 3'd1,
    SEND1 = 3'd2,
    SEND2 = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    SERVED_MAN = 1'b0,
    SERVED_SCR = 1'b1
  } served_e;

  typedef struct packed {
    logic [BYTE_W-1:0] game_state;
    logic [BYTE_W-1:0] operate;
    logic [BYTE_W-1:0] target;
  } frame_t;

  // Select byte n of a frame; n=0 is the first byte on the wire
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] f,
                                                   input logic [1:0]         idx);
    case (idx)
      2'd0:    return f[BYTE0_LSB +: BYTE_W];
      2'd1:    return f[BYTE1_LSB +: BYTE_W];
      default: return f[BYTE2_LSB +: BYTE_W];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie, the requester not served last wins.
module rr_pick2
  import uart_tx_arbiter_pkg::*;
(
  input  logic [GRANT_W-1:0] req_i,
  input  served_e            last_served_i,
  output logic [GRANT_W-1:0] pick_c_o
);

  // One-hot winner from {scr, man} requests
  always_comb begin
    pick_c_o = GRANT_NONE;
    case (req_i)
      2'b01:   pick_c_o = GRANT_MAN;
      2'b10:   pick_c_o = GRANT_SCR;
      2'b11:   pick_c_o = (last_served_i == SERVED_MAN) ? GRANT_SCR : GRANT_MAN;
      default: pick_c_o = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates manual and script 3-byte frames onto a single UART byte stream.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 4096,
  parameter logic [BYTE_W-1:0] IDLE_BYTE      = 8'h00
) (
  input  logic               uart_clk,
  input  logic               reset,
  input  logic               man_req,
  input  logic [FRAME_W-1:0] man_frame,
  output logic               man_ack,
  input  logic               scr_req,
  input  logic [FRAME_W-1:0] scr_frame,
  output logic               scr_ack,
  input  logic               script_loading,
  output logic [BYTE_W-1:0]  data_in_bits,
  input  logic               data_in_ready,
  output logic [GRANT_W-1:0] grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q,   state_d;
  frame_t               frame_q,   frame_d;
  served_e              last_q,    last_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [GRANT_W-1:0]   grant_q,   grant_d;
  logic                 busy_q,    busy_d;
  logic                 man_ack_q, man_ack_d;
  logic                 scr_ack_q, scr_ack_d;
  logic                 tmo_q,     tmo_d;
  logic [BYTE_W-1:0]    data_q,    data_d;

  logic [GRANT_W-1:0]   pick_c;
  logic [FRAME_W-1:0]   win_frame_c;

  rr_pick2 u_rr_pick2 (
    .req_i         ({scr_req, man_req}),
    .last_served_i (last_q),
    .pick_c_o      (pick_c)
  );

  assign win_frame_c = (pick_c == GRANT_SCR) ? scr_frame : man_frame;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    man_ack_d = 1'b0;
    scr_ack_d = 1'b0;
    tmo_d     = 1'b0;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        data_d = IDLE_BYTE;
        if (!script_loading && (pick_c != GRANT_NONE)) begin
          frame_d = frame_t'(win_frame_c);
          grant_d = pick_c;
          busy_d  = 1'b1;
          cnt_d   = '0;
          data_d  = frame_byte(win_frame_c, 2'd0);
          state_d = SEND0;
        end
      end

      SEND0, SEND1, SEND2: begin
        if (data_in_ready) begin
          cnt_d = '0;
          case (state_q)
            SEND0: begin
              state_d = SEND1;
              data_d  = frame_byte(frame_q, 2'd1);
            end
            SEND1: begin
              state_d = SEND2;
              data_d  = frame_byte(frame_q, 2'd2);
            end
            default: begin
              state_d   = DONE;
              data_d    = IDLE_BYTE;
              grant_d   = GRANT_NONE;
              busy_d    = 1'b0;
              man_ack_d = (grant_q == GRANT_MAN);
              scr_ack_d = (grant_q == GRANT_SCR);
              last_d    = (grant_q == GRANT_SCR) ? SERVED_SCR : SERVED_MAN;
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          // Abort: no ack and the round-robin history is left untouched
          state_d = IDLE;
          cnt_d   = '0;
          data_d  = IDLE_BYTE;
          grant_d = GRANT_NONE;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        data_d  = IDLE_BYTE;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        data_d  = IDLE_BYTE;
        grant_d = GRANT_NONE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      last_q    <= SERVED_MAN;
      cnt_q     <= '0;
      grant_q   <= GRANT_NONE;
      busy_q    <= 1'b0;
      man_ack_q <= 1'b0;
      scr_ack_q <= 1'b0;
      tmo_q     <= 1'b0;
      data_q    <= IDLE_BYTE;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      man_ack_q <= man_ack_d;
      scr_ack_q <= scr_ack_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
    end
  end

  assign man_ack      = man_ack_q;
  assign scr_ack      = scr_ack_q;
  assign timeout_err  = tmo_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign data_in_bits = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected events, monitor checks them.
module tb_uart_tx_arbiter;

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_AMAN = 2'd1;
  localparam logic [1:0] K_ASCR = 2'd2;
  localparam logic [1:0] K_TMO  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] gnt;
    logic [7:0] data;
  } ev_t;

  logic        uart_clk;
  logic        reset;
  logic        man_req;
  logic [23:0] man_frame;
  logic        man_ack;
  logic        scr_req;
  logic [23:0] scr_frame;
  logic        scr_ack;
  logic        script_loading;
  logic [7:0]  data_in_bits;
  logic        data_in_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  int  n_vec = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  bit  rsp_en      = 1'b1;
  int  rsp_delay   = 0;
  bit  stray_ready = 1'b0;

  uart_tx_arbiter #(
    .TIMEOUT_CYCLES (16),
    .IDLE_BYTE      (8'h00)
  ) dut (
    .uart_clk       (uart_clk),
    .reset          (reset),
    .man_req        (man_req),
    .man_frame      (man_frame),
    .man_ack        (man_ack),
    .scr_req        (scr_req),
    .scr_frame      (scr_frame),
    .scr_ack        (scr_ack),
    .script_loading (script_loading),
    .data_in_bits   (data_in_bits),
    .data_in_ready  (data_in_ready),
    .grant          (grant),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] g, input logic [23:0] f, input logic [1:0] ack_kind);
    logic [23:0] fv;
    fv = f;
    exp_q.push_back('{kind: K_BYTE, gnt: g, data: fv[23:16]});
    exp_q.push_back('{kind: K_BYTE, gnt: g, data: fv[15:8]});
    exp_q.push_back('{kind: K_BYTE, gnt: g, data: fv[7:0]});
    exp_q.push_back('{kind: ack_kind, gnt: 2'b00, data: 8'h00});
  endtask

  task automatic wait_ack(input bit scr, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge uart_clk);
      seen = scr ? scr_ack : man_ack;
    end
    chk(scr ? "scr_ack_seen" : "man_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_data(input logic [7:0] b, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge uart_clk);
      seen = busy && (data_in_bits == b);
    end
    chk("byte_presented", 32'(seen), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge uart_clk);
    chk("events_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic observe(input ev_t act);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d grant=%b data=%02h, expected none",
               act.kind, act.gnt, act.data);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL event: got kind=%0d grant=%b data=%02h, expected kind=%0d grant=%b data=%02h",
                 act.kind, act.gnt, act.data, e.kind, e.gnt, e.data);
      end
    end
  endtask

  // UART model: pulse data_in_ready rsp_delay cycles after each byte is presented
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    data_in_ready = 1'b0;
    forever begin
      @(posedge uart_clk);
      #1;
      data_in_ready = stray_ready;
      if (busy && rsp_en) begin
        if (wait_cnt == rsp_delay) begin
          data_in_ready = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: turn DUT activity into events and check them against the queue
  always @(negedge uart_clk) begin
    if (!reset) begin
      if (data_in_ready && busy) observe('{kind: K_BYTE, gnt: grant, data: data_in_bits});
      if (man_ack)               observe('{kind: K_AMAN, gnt: grant, data: data_in_bits});
      if (scr_ack)               observe('{kind: K_ASCR, gnt: grant, data: data_in_bits});
      if (timeout_err)           observe('{kind: K_TMO,  gnt: grant, data: data_in_bits});
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cnt;
    int k_hit;

    // Reset with both requesters already pending
    reset          = 1'b1;
    script_loading = 1'b0;
    man_req        = 1'b1;
    scr_req        = 1'b1;
    man_frame      = 24'h112233;
    scr_frame      = 24'hA1B2C3;
    repeat (3) @(negedge uart_clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_acks", 32'({man_ack, scr_ack}), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_data", 32'(data_in_bits), 32'h00);

    // Tie from reset: script, manual, script again
    rsp_delay = 0;
    push_frame(2'b10, 24'hA1B2C3, K_ASCR);
    push_frame(2'b01, 24'h112233, K_AMAN);
    push_frame(2'b10, 24'hA1B2C3, K_ASCR);
    reset = 1'b0;
    wait_ack(1'b1, 40);
    wait_ack(1'b0, 40);
    wait_ack(1'b1, 40);
    man_req = 1'b0;
    scr_req = 1'b0;
    drain(20);

    // Manual only, slow UART
    rsp_delay = 5;
    man_frame = 24'h010A03;
    push_frame(2'b01, 24'h010A03, K_AMAN);
    man_req = 1'b1;
    wait_ack(1'b0, 100);
    man_req = 1'b0;
    drain(20);

    // Timeout in SEND1 on a script frame; requester drops mid-frame
    rsp_delay = 2;
    scr_frame = 24'h556677;
    exp_q.push_back('{kind: K_BYTE, gnt: 2'b10, data: 8'h55});
    exp_q.push_back('{kind: K_TMO,  gnt: 2'b00, data: 8'h00});
    scr_req = 1'b1;
    wait_data(8'h66, 40);
    rsp_en  = 1'b0;
    scr_req = 1'b0;
    k_hit = 0;
    for (int k = 2; k <= 40 && k_hit == 0; k++) begin
      @(negedge uart_clk);
      if (timeout_err) k_hit = k;
    end
    chk("tmo_cycle", 32'(k_hit), 32'd17);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_data", 32'(data_in_bits), 32'h00);
    rsp_en = 1'b1;
    drain(20);

    // Tie after timeout: manual was last completed, so script wins
    rsp_delay = 1;
    man_frame = 24'h0F0E0D;
    scr_frame = 24'h1C1B1A;
    push_frame(2'b10, 24'h1C1B1A, K_ASCR);
    man_req = 1'b1;
    scr_req = 1'b1;
    wait_ack(1'b1, 60);
    man_req = 1'b0;
    scr_req = 1'b0;
    drain(20);

    // script_loading blocks grants; rising mid-frame does not abort
    scr_frame      = 24'h313233;
    script_loading = 1'b1;
    scr_req        = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge uart_clk);
      if (busy || grant != 2'b00) cnt++;
    end
    chk("load_block", 32'(cnt), 32'd0);
    push_frame(2'b10, 24'h313233, K_ASCR);
    script_loading = 1'b0;
    @(negedge uart_clk);
    chk("load_release_grant", 32'(grant), 32'h2);
    wait_data(8'h32, 20);
    script_loading = 1'b1;
    wait_ack(1'b1, 40);
    cnt = 0;
    repeat (8) begin
      @(negedge uart_clk);
      if (busy || grant != 2'b00) cnt++;
    end
    chk("load_after_frame", 32'(cnt), 32'd0);
    scr_req        = 1'b0;
    script_loading = 1'b0;
    drain(20);

    // Frame is latched at grant; later input changes are ignored
    rsp_delay = 3;
    scr_frame = 24'hDEADBE;
    push_frame(2'b10, 24'hDEADBE, K_ASCR);
    scr_req = 1'b1;
    wait_data(8'hDE, 20);
    scr_frame = 24'h123456;
    scr_req   = 1'b0;
    wait_ack(1'b1, 60);
    drain(20);

    // Reset during SEND1 aborts silently
    man_frame = 24'h7A7B7C;
    exp_q.push_back('{kind: K_BYTE, gnt: 2'b01, data: 8'h7A});
    man_req = 1'b1;
    wait_data(8'h7B, 40);
    reset   = 1'b1;
    man_req = 1'b0;
    @(negedge uart_clk);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_acks", 32'({man_ack, scr_ack}), 32'h0);
    chk("midrst_tmo", 32'(timeout_err), 32'h0);
    chk("midrst_data", 32'(data_in_bits), 32'h00);
    reset = 1'b0;
    repeat (10) @(negedge uart_clk);
    drain(5);

    // data_in_ready while idle is ignored
    stray_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge uart_clk);
      if (busy || grant != 2'b00 || data_in_bits != 8'h00) cnt++;
    end
    chk("idle_ready_ignored", 32'(cnt), 32'd0);
    stray_ready = 1'b0;
    repeat (3) @(negedge uart_clk);
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
